pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage RV32 core. It generates per-stage write-enable, flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It detects load-use hazards and resolves taken branches from EX. It freezes the pipeline during multi-cycle data-memory accesses and halts on memory timeout. Stall and flush events are counted for performance monitoring.

Parameters:
CNT_W, 16, width of the saturating stall_cnt and flush_cnt counters
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before HALT (legal range 1 to 2^16-1)

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
id_rs1  in  5  rs1 index of the instruction in ID
id_rs2  in  5  rs2 index of the instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
id_ex_MemRead  in  1  instruction in EX is a load
id_ex_wr  in  5  destination register of the instruction in EX
ex_branch_taken  in  1  branch/jump in EX resolved taken
dmem_req  in  1  MEM-stage instruction is accessing data memory
dmem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID cleared to NOP on next edge
id_ex_write  out  1  ID/EX load enable
id_ex_bubble  out  1  ID/EX control fields loaded as zero (NOP)
ex_mem_write  out  1  EX/MEM load enable
mem_wb_bubble  out  1  MEM/WB control fields loaded as zero
state_o  out  2  0=RUN, 1=MEM_WAIT, 2=HALT
mem_timeout  out  1  sticky error flag, set on entry to HALT
stall_cnt  out  CNT_W  cycles with pc_write=0 outside HALT, saturating
flush_cnt  out  CNT_W  taken-branch flush events, saturating

Behaviour:
- Reset (async, rst=1): state RUN, wait counter 0, mem_timeout 0, stall_cnt 0, flush_cnt 0. While rst=1, all *_write outputs are 0 and if_id_flush, id_ex_bubble and mem_wb_bubble are 1. Reset asserted mid-MEM_WAIT or in HALT returns to RUN immediately.
- Control outputs are combinational from state and inputs, with zero latency to the edge they control. Default is all writes 1 and all flush/bubble 0.
- lu_hazard = id_ex_MemRead & (id_ex_wr!=0) & ((id_uses_rs1 & id_rs1==id_ex_wr) | (id_uses_rs2 & id_rs2==id_ex_wr)).
- mem_stall = dmem_req & ~dmem_ready.
- Priority is HALT > mem_stall/MEM_WAIT > branch > load-use.
  - HALT: all writes 0, mem_wb_bubble=1, all other flush/bubble 0. HALT is held until reset.
  - mem_stall (RUN or MEM_WAIT): pc_write, if_id_write, id_ex_write and ex_mem_write are 0; mem_wb_bubble=1. Branch and load-use are ignored. The stalled branch stays in EX and re-asserts after the freeze.
  - ex_branch_taken: if_id_flush=1 and id_ex_bubble=1; writes stay 1. A simultaneous lu_hazard is suppressed because the hazarding instruction is squashed.
  - lu_hazard: pc_write=0, if_id_write=0, id_ex_bubble=1. This is a 1-cycle stall.
- FSM transitions:
  - RUN→MEM_WAIT when mem_stall; wait counter set to 1.
  - MEM_WAIT→RUN when dmem_ready, or when dmem_req drops; wait counter cleared. The edge with dmem_ready=1 is not a frozen edge.
  - MEM_WAIT: wait counter +1 per stalled cycle. When the counter reaches MEM_TIMEOUT and mem_stall is still 1, go to HALT and set mem_timeout=1.
- Counters:
  - stall_cnt +1 on each edge with pc_write=0 outside HALT and rst=0.
  - flush_cnt +1 on each edge where the branch flush takes effect.
  - Both saturate at 2^CNT_W-1 and do not wrap.

Test Plan:
- Load-use: id_ex_MemRead=1, id_ex_wr=5, id_rs2=5, id_uses_rs2=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly 1 cycle; stall_cnt 0→1.
- x0 and unused source: id_ex_wr=0 with id_rs1=0, or id_uses_rs1=0 with the index matching -> no stall; all writes 1.
- Branch+load-use same cycle: ex_branch_taken=1 and lu_hazard=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_cnt 0→1; stall_cnt unchanged.
- Memory wait: dmem_req=1, dmem_ready low for 3 cycles then high -> state_o 1 for 3 cycles, ex_mem_write=0 and mem_wb_bubble=1 during the wait; RUN on the ready edge; stall_cnt=3. A concurrent ex_branch_taken produces no flush until the wait ends.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> HALT after the 4th wait cycle; mem_timeout=1; outputs frozen indefinitely; rst returns state to RUN and clears the flag.
- Async reset mid-wait: assert rst between clock edges in MEM_WAIT -> state_o=0 and counters 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline stall/flush/bubble controller
// Load-use and branch hazards, data-memory freeze with timeout halt, saturating event counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_ex_MemRead,
    input  logic [4:0]       id_ex_wr,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             mem_wb_bubble,
    output logic [1:0]       state_o,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [15:0]      wait_q, wait_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic lu_hazard;
    logic mem_stall;

    assign lu_hazard = id_ex_MemRead && (id_ex_wr != 5'd0) &&
                       ((id_uses_rs1 && (id_rs1 == id_ex_wr)) ||
                        (id_uses_rs2 && (id_rs2 == id_ex_wr)));
    assign mem_stall = dmem_req && !dmem_ready;

    // Highest-priority condition wins; outputs steer the very next edge.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_write  = 1'b1;
        mem_wb_bubble = 1'b0;
        if (rst) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (state_q == HALT || mem_stall) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (lu_hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    wait_d  = 16'd1;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d = RUN;
                    wait_d  = 16'd0;
                end else if (wait_q >= TMO) begin
                    state_d   = HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: state_d = HALT;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_write && state_q != HALT && stall_q != {CNT_W{1'b1}})
            stall_d = stall_q + CNT_W'(1);
        if (if_id_flush && flush_q != {CNT_W{1'b1}})
            flush_d = flush_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= 16'd0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign state_o     = state_q;
    assign mem_timeout = timeout_q;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scenario tasks with an expected-control scoreboard for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam int TMO   = 4;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble}
    localparam logic [6:0] C_NORM = 7'b1101010;
    localparam logic [6:0] C_LU   = 7'b0001110;
    localparam logic [6:0] C_BR   = 7'b1111110;
    localparam logic [6:0] C_FRZ  = 7'b0000001;
    localparam logic [6:0] C_RST  = 7'b0010101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_ex_wr = '0;
    logic id_uses_rs1 = 0, id_uses_rs2 = 0, id_ex_MemRead = 0;
    logic ex_branch_taken = 0, dmem_req = 0, dmem_ready = 0;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble;
    logic [1:0] state_o;
    logic mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0] ctl;
    logic [8:0] exp_q[$];
    logic [8:0] e;
    int tests = 0;
    int fails = 0;

    assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_ex_MemRead(id_ex_MemRead), .id_ex_wr(id_ex_wr), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write),
        .mem_wb_bubble(mem_wb_bubble), .state_o(state_o), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // lu=1 sets up an rs2 load-use match on x5.
    task automatic drive(input logic lu, input logic br, input logic req, input logic rdy);
        id_ex_MemRead   = lu;
        id_ex_wr        = 5'd5;
        id_rs2          = 5'd5;
        id_uses_rs2     = lu;
        id_rs1          = 5'd1;
        id_uses_rs1     = 1'b0;
        ex_branch_taken = br;
        dmem_req        = req;
        dmem_ready      = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1, 1, 0);
        exp_q.push_back({C_RST, 2'd0});
        #1;
        e = exp_q.pop_front();
        tests++;
        if ({ctl, state_o} !== e) begin
            fails++;
            $display("FAIL reset_ctl got %b exp %b", {ctl, state_o}, e);
        end
        tests++;
        if ({mem_timeout, stall_cnt, flush_cnt} !== 9'd0) begin
            fails++;
            $display("FAIL reset_regs got %b exp 0", {mem_timeout, stall_cnt, flush_cnt});
        end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0);
    endtask

    task automatic test_load_use();
        logic [6:0] seq [3];
        seq = '{C_LU, C_NORM, C_NORM};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(i == 0, 0, 0, 0);
            exp_q.push_back({seq[i], 2'd0});
            #1;
            e = exp_q.pop_front();
            tests++;
            if ({ctl, state_o} !== e) begin
                fails++;
                $display("FAIL load_use[%0d] got %b exp %b", i, {ctl, state_o}, e);
            end
        end
        tests++;
        if (stall_cnt !== 4'd1) begin
            fails++;
            $display("FAIL load_use_stall_cnt got %0d exp 1", stall_cnt);
        end
    endtask

    task automatic test_x0_unused();
        // {MemRead, wr, rs1, uses_rs1, expected ctl}
        logic [18:0] tbl [4];
        tbl = '{{1'b1, 5'd0, 5'd0, 1'b1, C_NORM},
                {1'b1, 5'd7, 5'd7, 1'b0, C_NORM},
                {1'b1, 5'd7, 5'd7, 1'b1, C_LU},
                {1'b0, 5'd7, 5'd7, 1'b1, C_NORM}};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0);
            {id_ex_MemRead, id_ex_wr, id_rs1, id_uses_rs1} = tbl[i][18:7];
            exp_q.push_back({tbl[i][6:0], 2'd0});
            #1;
            e = exp_q.pop_front();
            tests++;
            if ({ctl, state_o} !== e) begin
                fails++;
                $display("FAIL x0_unused[%0d] got %b exp %b", i, {ctl, state_o}, e);
            end
        end
    endtask

    task automatic test_branch_lu();
        do_reset();
        @(negedge clk);
        drive(1, 1, 0, 0);
        exp_q.push_back({C_BR, 2'd0});
        #1;
        e = exp_q.pop_front();
        tests++;
        if ({ctl, state_o} !== e) begin
            fails++;
            $display("FAIL branch_lu got %b exp %b", {ctl, state_o}, e);
        end
        @(negedge clk);
        drive(0, 0, 0, 0);
        tests++;
        if ({flush_cnt, stall_cnt} !== {4'd1, 4'd0}) begin
            fails++;
            $display("FAIL branch_lu_cnts got flush=%0d stall=%0d exp flush=1 stall=0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        logic [8:0] seq [5];
        seq = '{{C_FRZ, 2'd0}, {C_FRZ, 2'd1}, {C_FRZ, 2'd1}, {C_BR, 2'd1}, {C_NORM, 2'd0}};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(0, i < 4, i < 4, i == 3);
            exp_q.push_back(seq[i]);
            #1;
            e = exp_q.pop_front();
            tests++;
            if ({ctl, state_o} !== e) begin
                fails++;
                $display("FAIL mem_wait[%0d] got %b exp %b", i, {ctl, state_o}, e);
            end
        end
        tests++;
        if ({stall_cnt, flush_cnt} !== {4'd3, 4'd1}) begin
            fails++;
            $display("FAIL mem_wait_cnts got stall=%0d flush=%0d exp stall=3 flush=1", stall_cnt, flush_cnt);
        end
        // dmem_req dropping without ready also releases the freeze
        @(negedge clk);
        drive(0, 0, 1, 0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        exp_q.push_back({C_NORM, 2'd1});
        #1;
        e = exp_q.pop_front();
        tests++;
        if ({ctl, state_o} !== e) begin
            fails++;
            $display("FAIL req_drop got %b exp %b", {ctl, state_o}, e);
        end
        @(negedge clk);
        tests++;
        if (state_o !== 2'd0) begin
            fails++;
            $display("FAIL req_drop_run got %0d exp 0", state_o);
        end
    endtask

    task automatic test_timeout();
        logic [1:0] st [10];
        st = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 5) drive(0, 0, 1, 0);
            else drive(i[0], 1, i[1], i[2]);
            exp_q.push_back({C_FRZ, st[i]});
            #1;
            e = exp_q.pop_front();
            tests++;
            if ({ctl, state_o} !== e) begin
                fails++;
                $display("FAIL timeout[%0d] got %b exp %b", i, {ctl, state_o}, e);
            end
        end
        tests++;
        if ({mem_timeout, stall_cnt, flush_cnt} !== {1'b1, 4'd5, 4'd0}) begin
            fails++;
            $display("FAIL halt_regs got to=%0d stall=%0d flush=%0d exp to=1 stall=5 flush=0",
                     mem_timeout, stall_cnt, flush_cnt);
        end
        do_reset();
        #1;
        tests++;
        if ({state_o, mem_timeout} !== 3'd0) begin
            fails++;
            $display("FAIL halt_exit got state=%0d to=%0d exp 0 0", state_o, mem_timeout);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(0, 0, 1, 0);
        end
        #2;
        rst = 1'b1;
        exp_q.push_back({C_RST, 2'd0});
        #1;
        e = exp_q.pop_front();
        tests++;
        if ({ctl, state_o} !== e || stall_cnt !== 4'd0) begin
            fails++;
            $display("FAIL async_reset got %b stall=%0d exp %b stall=0", {ctl, state_o}, stall_cnt, e);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(1, 0, 0, 0);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(0, 1, 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0);
        tests++;
        if ({stall_cnt, flush_cnt} !== 8'hFF) begin
            fails++;
            $display("FAIL saturation got stall=%0d flush=%0d exp 15 15", stall_cnt, flush_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0_unused();
        test_branch_lu();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
